// File: rtl/fp32_pkg.sv
// ============================================================================
// Module   : fp32_pkg
// Brief    : Shared fp32 field layout, int32 limits and rounding modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fp32_pkg;

  localparam int          FP32_EXP_BIAS = 127;
  localparam logic [7:0]  FP32_EXP_MAX  = 8'hFF;
  localparam logic [31:0] INT32_MAX     = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN     = 32'h8000_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic {
    RM_RTZ = 1'b0,
    RM_RNE = 1'b1
  } round_mode_e;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_ctl.sv
// ============================================================================
// Module   : pipe_stage_ctl
// Brief    : One pipeline stage valid bit with bubble-collapsing ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_ctl (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  input  logic i_ready_next,
  output logic o_valid,
  output logic o_ready
);

  logic r_valid;

  assign o_ready = ~r_valid | i_ready_next;
  assign o_valid = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (o_ready) begin
      r_valid <= i_valid;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp32_to_int32.sv
// ============================================================================
// Module   : fp32_to_int32
// Brief    : 3-stage fp32 -> int32 converter (unpack, align, round/saturate).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp32_to_int32
  import fp32_pkg::*;
#(
  parameter logic [31:0] NAN_RESULT = 32'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid,
  output logic        out_inexact
);

  localparam logic [7:0] c_EXP_ONE  = 8'(FP32_EXP_BIAS);
  localparam logic [7:0] c_EXP_HALF = 8'(FP32_EXP_BIAS - 1);
  localparam logic [7:0] c_EXP_OVF  = 8'(FP32_EXP_BIAS + 31);

  logic w_v1, w_v2, w_v3;
  logic w_rdy1, w_rdy2, w_rdy3;

  pipe_stage_ctl u_s1 (
    .clk(clk), .rst_n(rst_n), .i_valid(in_valid), .i_ready_next(w_rdy2),
    .o_valid(w_v1), .o_ready(w_rdy1)
  );
  pipe_stage_ctl u_s2 (
    .clk(clk), .rst_n(rst_n), .i_valid(w_v1), .i_ready_next(w_rdy3),
    .o_valid(w_v2), .o_ready(w_rdy2)
  );
  pipe_stage_ctl u_s3 (
    .clk(clk), .rst_n(rst_n), .i_valid(w_v2), .i_ready_next(out_ready),
    .o_valid(w_v3), .o_ready(w_rdy3)
  );

  assign in_ready  = w_rdy1;
  assign out_valid = w_v3;

  // ---------------- S1: unpack / classify ----------------
  fp32_t       w_in;
  logic        r1_sign, r1_nan;
  logic [7:0]  r1_exp;
  logic [23:0] r1_sig;
  round_mode_e r1_rm;

  assign w_in = in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_sign <= 1'b0;
      r1_nan  <= 1'b0;
      r1_exp  <= 8'd0;
      r1_sig  <= 24'd0;
      r1_rm   <= RM_RTZ;
    end else if (w_rdy1) begin
      r1_sign <= w_in.sign;
      r1_nan  <= (w_in.exp == FP32_EXP_MAX) && (w_in.frac != 23'd0);
      r1_exp  <= w_in.exp;
      r1_sig  <= {w_in.exp != 8'd0, w_in.frac};
      r1_rm   <= round_mode_e'(in_rm);
    end
  end

  // ---------------- S2: align ----------------
  logic        w_frac_nz;
  logic [4:0]  w_sh;
  logic [53:0] w_wide;
  logic [30:0] w_mag;
  logic        w_g, w_s, w_ovf, w_min;

  assign w_frac_nz = |r1_sig[22:0];
  // (e - 127) mod 32 == (e + 1) mod 32; only used when 0 <= e-127 <= 30
  assign w_sh      = r1_exp[4:0] + 5'd1;
  assign w_wide    = {30'd0, r1_sig} << w_sh;

  always_comb begin
    w_mag = 31'd0;
    w_g   = 1'b0;
    w_s   = 1'b0;
    w_ovf = 1'b0;
    w_min = 1'b0;
    if (r1_exp >= c_EXP_OVF) begin
      if (r1_sign && (r1_exp == c_EXP_OVF) && !w_frac_nz) w_min = 1'b1;
      else                                               w_ovf = 1'b1;
    end else if (r1_exp >= c_EXP_ONE) begin
      w_mag = w_wide[53:23];
      w_g   = w_wide[22];
      w_s   = |w_wide[21:0];
    end else if (r1_exp == c_EXP_HALF) begin
      w_g = 1'b1;
      w_s = w_frac_nz;
    end else begin
      w_s = |r1_sig;
    end
  end

  logic        r2_sign, r2_nan, r2_ovf, r2_min, r2_g, r2_s;
  logic [30:0] r2_mag;
  round_mode_e r2_rm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_sign <= 1'b0;
      r2_nan  <= 1'b0;
      r2_ovf  <= 1'b0;
      r2_min  <= 1'b0;
      r2_g    <= 1'b0;
      r2_s    <= 1'b0;
      r2_mag  <= 31'd0;
      r2_rm   <= RM_RTZ;
    end else if (w_rdy2) begin
      r2_sign <= r1_sign;
      r2_nan  <= r1_nan;
      r2_ovf  <= w_ovf;
      r2_min  <= w_min;
      r2_g    <= w_g;
      r2_s    <= w_s;
      r2_mag  <= w_mag;
      r2_rm   <= r1_rm;
    end
  end

  // ---------------- S3: round / sign / saturate ----------------
  logic        w_inc;
  logic [31:0] w_sum;
  logic [31:0] w_data;
  logic        w_inv, w_inx;

  assign w_inc = (r2_rm == RM_RNE) & r2_g & (r2_s | r2_mag[0]);
  assign w_sum = {1'b0, r2_mag} + {31'd0, w_inc};

  always_comb begin
    w_data = 32'd0;
    w_inv  = 1'b0;
    w_inx  = 1'b0;
    if (r2_nan) begin
      w_data = NAN_RESULT;
      w_inv  = 1'b1;
    end else if (r2_ovf || (!r2_sign && w_sum[31])) begin
      w_data = r2_sign ? INT32_MIN : INT32_MAX;
      w_inv  = 1'b1;
    end else if (r2_min) begin
      w_data = INT32_MIN;
    end else begin
      // a negative magnitude of exactly 2^31 negates to INT32_MIN on its own
      w_data = r2_sign ? (32'd0 - w_sum) : w_sum;
      w_inx  = r2_g | r2_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= 32'd0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else if (w_rdy3) begin
      out_data    <= w_data;
      out_invalid <= w_inv;
      out_inexact <= w_inx;
    end
  end

endmodule

`default_nettype wire

// File: doc/fp32_to_int32.md
Name: fp32_to_int32

Overview:
- Pipelined converter from IEEE-754 fp32 to signed int32, the reading end of the fp32 adder datapath.
- Consumes adder results and hands integer values to control and indexing logic.
- Three register stages with valid/ready flow control per stage.
- Selectable rounding mode, saturating out-of-range results, and invalid/inexact flags.

Parameters:
NAN_RESULT, 32'h7FFF_FFFF, int32 value returned for any NaN input.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data/in_rm are valid this cycle.
in_ready  output  1  stage 1 can accept; transfer when in_valid & in_ready.
in_data  input  32  fp32 operand (sign[31], exp[30:23], frac[22:0]).
in_rm  input  1  rounding mode: 0 = toward zero, 1 = nearest-even.
out_valid  output  1  out_data/flags valid.
out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
out_data  output  32  signed int32 result.
out_invalid  output  1  NaN, infinity or out-of-range input (result saturated).
out_inexact  output  1  discarded fraction bits were nonzero; never set together with out_invalid.

Behaviour:
Reset:
- rst_n low asynchronously clears all stage valid bits: out_valid = 0.
- Data registers clear to 0: out_data = 0, out_invalid = 0, out_inexact = 0.
- Transactions in flight during reset are dropped. No output appears until new input is accepted after rst_n rises.

Flow control:
- ready_k = ~valid_k | ready_(k+1), with ready_4 = out_ready and in_ready = ready_1. The chain is combinational.
- A stage loads when its own ready is high. A stalled stage holds data and valid unchanged.
- Bubbles collapse: with out_ready low, 3 transactions are held and in_ready then falls.
- Latency is 3 cycles from accept to out_valid when unstalled. Throughput is 1 per cycle.
- out_data and flags are stable while out_valid & ~out_ready.

S1, unpack/classify:
- Register sign, biased exponent e, 24-bit significand (hidden bit = (e != 0)), and rm.
- Classes:
  - nan: e = 255 and frac != 0.
  - inf: e = 255 and frac = 0.
  - zero/denormal: e = 0.

S2, align (u = e - 127):
- u >= 31: flag overflow, except sign=1, u=31, frac=0 (exactly -2^31), which is legal.
- 0 <= u <= 30: magnitude = sig shifted to integer position, giving a 31-bit integer part plus guard bit G and sticky S.
- u = -1: integer 0, G = 1, S = (frac != 0).
- u <= -2 or denormal: integer 0, G = 0, S = (sig != 0). Zero gives 0 with S = 0.

S3, round/sign/saturate:
- RNE increment = G & (S | lsb). RTZ increment = 0. inexact = G | S.
- Rounding up to 2^31 when positive → overflow.
- Negate when sign = 1. A negative magnitude of 2^31 → 32'h8000_0000, valid.

Special results:
- NaN → NAN_RESULT, invalid.
- +inf or +overflow → 32'h7FFF_FFFF, invalid.
- -inf or -overflow → 32'h8000_0000, invalid.
- inexact = 0 whenever invalid = 1.
- -0 → 0, exact.

Decomposition:
- Shared package fp32_pkg holds:
  - FP32_EXP_BIAS = 127, FP32_EXP_MAX = 8'hFF.
  - INT32_MAX, INT32_MIN.
  - typedef fp32_t (packed struct sign/exp/frac).
  - enum round_mode_e {RM_RTZ, RM_RNE}.
  - The same package serves the adder.
- One natural sub-module: pipe_stage_ctl (valid register plus ready equation), instantiated three times. The datapath stays inline.

Test Plan:
1. 0x3FC00000 (1.5): rm=1 → 2, inexact; rm=0 → 1, inexact. 0x3F000000 (0.5) rm=1 → 0, inexact (tie to even).
2. 0x40200000 (2.5) rm=1 → 2. 0xC0600000 (-3.5) rm=1 → 0xFFFFFFFC. 0x4B000001 (8388609.0) → 8388609 exact.
3. 0xCF000000 (-2^31) → 0x80000000, no flags. 0x4F000000 (2^31) → 0x7FFFFFFF, invalid. 0x4EFFFFFF → 0x7FFFFF80 exact.
4. 0x7FC00000 → 0x7FFFFFFF, invalid. 0xFF800000 → 0x80000000, invalid. 0x00000001 → 0, inexact. 0x80000000 → 0, no flags.
5. Back-to-back stream of 1.0, 2.0, 3.0, 4.0, 5.0 with out_ready held low 6 cycles → in_ready low after 3 accepts. On release, outputs 1..5 in order with no loss or duplication, and out_data stable while stalled.
6. Assert rst_n low mid-stream with 2 items in flight → out_valid = 0 immediately. After release, new input 0x41200000 → 10 after 3 cycles.
